// File: rtl/even_sample_fifo_pkg.sv
// even_fifo_pkg: shared constants and helpers for even_sample_fifo.
package even_fifo_pkg;
    localparam int ODD_CNT_W = 8;
    localparam logic [ODD_CNT_W-1:0] ODD_CNT_MAX = 8'hFF;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/even_sample_fifo_if.sv
// even_sample_fifo_if: producer/consumer handshake and status bundle of even_sample_fifo.
interface even_sample_fifo_if
    import even_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = ptr_w(DEPTH) + 1;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        count;
    logic [ODD_CNT_W-1:0] odd_cnt;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, odd_cnt
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, odd_cnt
    );
endinterface

// File: rtl/even_sample_fifo_sat_counter.sv
// sat_counter: increments on inc and holds at all-ones until reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);
    logic [W-1:0] r_value;
    always_ff @(posedge clk) begin
        if (rst) r_value <= '0;
        else if (inc && r_value != '1) r_value <= r_value + W'(1);
    end
    assign value = r_value;
endmodule

// File: rtl/even_sample_fifo.sv
// even_sample_fifo: show-ahead FIFO storing only even words; odd words are dropped and counted.
// Define EVEN_SAMPLE_FIFO_ASSERT_EN to compile in the runtime property checks.
module even_sample_fifo
    import even_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    even_sample_fifo_if.slave  bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full, w_push, w_wr, w_odd, w_pop;
    assign w_full = r_count == CW'(DEPTH);
    assign w_push = bus.in_valid && bus.in_ready;
    assign w_wr   = w_push && !bus.in_data[0];
    assign w_odd  = w_push && bus.in_data[0];
    assign w_pop  = bus.out_valid && bus.out_ready;

    // in_ready gated by rst so nothing is accepted in the reset cycle
    assign bus.in_ready  = !rst && !w_full;
    assign bus.out_valid = r_count != '0;
    assign bus.out_data  = bus.out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.count     = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    sat_counter #(.W(ODD_CNT_W)) u_odd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_odd),
        .value (bus.odd_cnt)
    );

`ifdef EVEN_SAMPLE_FIFO_ASSERT_EN
    logic [ODD_CNT_W-1:0] r_prev_odd;
    always_ff @(posedge clk) begin
        r_prev_odd <= rst ? '0 : bus.odd_cnt;
        if (!rst) begin
            p0: assert (!bus.out_valid || !bus.out_data[0]);
            p1: assert (r_count <= CW'(DEPTH));
            p2: assert (!w_full || !bus.in_ready);
            p3: assert (r_count != '0 || bus.out_data == '0);
            p4: assert (bus.odd_cnt >= r_prev_odd);
        end
    end
`else
`endif
endmodule

// File: tb/tb_even_sample_fifo.sv
// tb_even_sample_fifo: directed stimulus with a queue scoreboard for even_sample_fifo.
module tb_even_sample_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 0;
    logic rst = 1;
    int   vectors = 0;
    int   errs = 0;
    logic [WIDTH-1:0] q[$];
    int   m_odd = 0;

    even_sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    even_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle, check outputs against the model before the edge, then update the model
    task automatic cycle(input logic v, input logic [31:0] d, input logic r);
        logic acc, pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && q.size() != DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("odd_cnt", 32'(bus.odd_cnt), 32'(m_odd));
        chk("out_data", bus.out_data, q.size() != 0 ? q[0] : 32'h0);
        acc = v && q.size() != DEPTH;
        pop = q.size() != 0 && r;
        if (rst) begin
            q.delete();
            m_odd = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && !d[0]) q.push_back(d);
            if (acc && d[0] && m_odd < 255) m_odd++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'(2 * i), 0);
        cycle(1, 8, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        cycle(0, 0, 0);
        for (int i = 0; i < 300; i++) cycle(1, 32'(2 * i + 1), 0);
        cycle(1, 10, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        cycle(1, 100, 0);
        cycle(1, 102, 0);
        for (int i = 0; i < 20; i++) cycle(1, 32'(200 + 2 * i), 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        rst = 1;
        cycle(0, 0, 0);
        rst = 0;
        for (int i = 0; i < 7; i++) cycle(1, 32'(2 * i + 1), 0);
        for (int i = 0; i < 3; i++) cycle(1, 32'(40 + 2 * i), 0);
        cycle(0, 0, 0);
        rst = 1;
        cycle(1, 50, 0);
        rst = 0;
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(1, 60, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
